// File: rtl/peakd_pkg.sv
// -----------------------------------------------------------------------------
// peakd_pkg -- shared definitions for the peak detector.
//   peakd_state_e : detector FSM states (IDLE / SEEK / TRACK)
//   PEAKD_IDXW    : default sample-index width
//   PEAKD_CNTW    : default peak-count width
// The sample width comes from the `DATAWIDTH macro (defaults to 16 here so
// the block elaborates stand-alone).
// Optional feature macro used by the block: PEAKD_HOLDOFF_EN.
// -----------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

package peakd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    TRACK = 2'd2
  } peakd_state_e;

  localparam int PEAKD_IDXW = 11;
  localparam int PEAKD_CNTW = 8;

endpackage

// File: rtl/peakd_holdoff.sv
// -----------------------------------------------------------------------------
// peakd_holdoff -- minimum-distance counter between detected peaks.
// Loaded with min_dist_i on each emission, then counts accepted samples down
// to zero. While nonzero the detector may not start tracking a new candidate.
// Only instantiated when PEAKD_HOLDOFF_EN is defined.
//   clk        : clock
//   reset_n    : synchronous active-high reset
//   clr_i      : clear counter (start of a new action)
//   load_i     : peak emitted this cycle, reload from min_dist_i
//   dec_i      : sample accepted this cycle
//   min_dist_i : holdoff length in accepted samples
//   idle_o     : counter is zero, tracking permitted
// -----------------------------------------------------------------------------
module peakd_holdoff (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] min_dist_i,
  output logic       idle_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next counter value: clear beats load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (load_i) begin
      cnt_d = min_dist_i;
    end else if (dec_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idle_o = (cnt_q == 8'd0);

endmodule

// File: rtl/peak_detect.sv
// -----------------------------------------------------------------------------
// peak_detect -- local-maximum detector on the moving-average sample stream.
// A peak is a rising run reaching at least `threshold`, reported when the
// first strictly lower sample arrives. Plateaus report their first index.
//   clk, reset_n : clock, synchronous active-high reset
//   start_act    : new action, clears detection context and statistics
//   peakd_en     : block enable (pass-through stays live when low)
//   vald_din     : sample valid; data_in is the sample
//   threshold    : minimum peak amplitude (unsigned)
//   data_out, valid_out : input stream delayed by one cycle
//   peak_valid   : one-cycle pulse per emitted peak
//   peak_val, peak_idx  : amplitude and index of the last peak
//   peak_cnt     : peaks since start_act (saturating)
//   min_dist     : holdoff in samples, only with PEAKD_HOLDOFF_EN defined
// -----------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module peak_detect
  import peakd_pkg::*;
#(
  parameter int DATAWIDTH = `DATAWIDTH,
  parameter int IDXW      = PEAKD_IDXW,
  parameter int CNTW      = PEAKD_CNTW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_act,
  input  logic                 peakd_en,
  input  logic                 vald_din,
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic [DATAWIDTH-1:0] threshold,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 peak_valid,
  output logic [DATAWIDTH-1:0] peak_val,
  output logic [IDXW-1:0]      peak_idx,
  output logic [CNTW-1:0]      peak_cnt
`ifdef PEAKD_HOLDOFF_EN
  ,
  input  logic [7:0]           min_dist
`endif
);

  localparam logic [IDXW-1:0] IDX_MAX = {IDXW{1'b1}};
  localparam logic [IDXW-1:0] IDX_ONE = {{(IDXW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  peakd_state_e         state_q, state_d;
  logic [DATAWIDTH-1:0] last_q, last_d;
  logic [DATAWIDTH-1:0] cand_val_q, cand_val_d;
  logic [IDXW-1:0]      cand_idx_q, cand_idx_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] pval_q, pval_d;
  logic [IDXW-1:0]      pidx_q, pidx_d;
  logic                 pvalid_q, pvalid_d;
  logic [DATAWIDTH-1:0] dout_q;
  logic                 vout_q;
  logic                 emit_s;
  logic                 accept_s;
  logic                 holdoff_ok_s;

  // A sample only counts when enabled and not being discarded by start_act.
  assign accept_s = vald_din && peakd_en && !start_act;

`ifdef PEAKD_HOLDOFF_EN
  peakd_holdoff u_holdoff (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (start_act),
    .load_i     (emit_s),
    .dec_i      (accept_s),
    .min_dist_i (min_dist),
    .idle_o     (holdoff_ok_s)
  );
`else
  assign holdoff_ok_s = 1'b1;
`endif

  // Next-state and output logic of the detector FSM.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cand_val_d = cand_val_q;
    cand_idx_d = cand_idx_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pval_d     = pval_q;
    pidx_d     = pidx_q;
    pvalid_d   = 1'b0;
    emit_s     = 1'b0;
    if (start_act) begin
      // Pending candidate is dropped, never emitted.
      state_d    = IDLE;
      last_d     = {DATAWIDTH{1'b0}};
      cand_val_d = {DATAWIDTH{1'b0}};
      cand_idx_d = {IDXW{1'b0}};
      idx_d      = {IDXW{1'b0}};
      cnt_d      = {CNTW{1'b0}};
      pval_d     = {DATAWIDTH{1'b0}};
      pidx_d     = {IDXW{1'b0}};
    end else if (!peakd_en) begin
      // Index restarts at 0 when the block is re-enabled.
      state_d    = IDLE;
      cand_val_d = {DATAWIDTH{1'b0}};
      cand_idx_d = {IDXW{1'b0}};
      idx_d      = {IDXW{1'b0}};
    end else if (vald_din) begin
      last_d = data_in;
      if (idx_q != IDX_MAX) begin
        idx_d = idx_q + IDX_ONE;
      end else begin
        idx_d = idx_q;
      end
      case (state_q)
        IDLE: begin
          state_d = SEEK;
        end
        SEEK: begin
          if ((data_in > last_q) && (data_in >= threshold) && holdoff_ok_s) begin
            state_d    = TRACK;
            cand_val_d = data_in;
            cand_idx_d = idx_q;
          end else begin
            state_d = SEEK;
          end
        end
        TRACK: begin
          if (data_in > cand_val_q) begin
            cand_val_d = data_in;
            cand_idx_d = idx_q;
          end else if (data_in < cand_val_q) begin
            emit_s   = 1'b1;
            pvalid_d = 1'b1;
            pval_d   = cand_val_q;
            pidx_d   = cand_idx_q;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end else begin
              cnt_d = cnt_q;
            end
            state_d = SEEK;
          end else begin
            // Equal sample: plateau keeps its first index.
            state_d = TRACK;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      // Valid gap: everything stalls.
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= IDLE;
      last_q     <= {DATAWIDTH{1'b0}};
      cand_val_q <= {DATAWIDTH{1'b0}};
      cand_idx_q <= {IDXW{1'b0}};
      idx_q      <= {IDXW{1'b0}};
      cnt_q      <= {CNTW{1'b0}};
      pval_q     <= {DATAWIDTH{1'b0}};
      pidx_q     <= {IDXW{1'b0}};
      pvalid_q   <= 1'b0;
      dout_q     <= {DATAWIDTH{1'b0}};
      vout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cand_val_q <= cand_val_d;
      cand_idx_q <= cand_idx_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pval_q     <= pval_d;
      pidx_q     <= pidx_d;
      pvalid_q   <= pvalid_d;
      dout_q     <= data_in;
      vout_q     <= vald_din;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign peak_valid = pvalid_q;
  assign peak_val   = pval_q;
  assign peak_idx   = pidx_q;
  assign peak_cnt   = cnt_q;

endmodule

// File: tb/tb_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_peak_detect -- self-checking bench for peak_detect.
// A behavioural model follows the detection rules sample by sample and every
// cycle's outputs are compared; directed sequences add fixed expectations.
// Builds with or without PEAKD_HOLDOFF_EN.
// -----------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module tb_peak_detect;

  localparam int DW      = `DATAWIDTH;
  localparam int IW      = 11;
  localparam int CW      = 8;
  localparam int IDX_MAX = (1 << IW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_act;
  logic          peakd_en;
  logic          vald_din;
  logic [DW-1:0] data_in;
  logic [DW-1:0] threshold;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          peak_valid;
  logic [DW-1:0] peak_val;
  logic [IW-1:0] peak_idx;
  logic [CW-1:0] peak_cnt;
  logic [7:0]    min_dist;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model context
  bit m_have_prev, m_tracking, m_pvalid, m_vout;
  int m_prev, m_cval, m_cidx, m_idx, m_cnt, m_pv, m_pi, m_hold, m_dout;
  int pk_q[$];
  int seq[$];
  int exp_q[$];

  always #5 clk = ~clk;

  peak_detect dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_act  (start_act),
    .peakd_en   (peakd_en),
    .vald_din   (vald_din),
    .data_in    (data_in),
    .threshold  (threshold),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .peak_valid (peak_valid),
    .peak_val   (peak_val),
    .peak_idx   (peak_idx),
    .peak_cnt   (peak_cnt)
`ifdef PEAKD_HOLDOFF_EN
    ,
    .min_dist   (min_dist)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the current inputs to the model for one clock edge.
  task automatic model_step();
    int d, cur, md;
    bit emit;
`ifdef PEAKD_HOLDOFF_EN
    md = int'(min_dist);
`else
    md = 0;
`endif
    m_pvalid = 1'b0;
    if (reset_n) begin
      m_have_prev = 0; m_tracking = 0; m_prev = 0; m_cval = 0; m_cidx = 0;
      m_idx = 0; m_cnt = 0; m_pv = 0; m_pi = 0; m_hold = 0;
      m_dout = 0; m_vout = 0;
    end else begin
      m_dout = int'(data_in);
      m_vout = vald_din;
      if (start_act) begin
        m_have_prev = 0; m_tracking = 0; m_idx = 0; m_cnt = 0;
        m_pv = 0; m_pi = 0; m_hold = 0;
      end else if (!peakd_en) begin
        m_have_prev = 0; m_tracking = 0; m_idx = 0;
      end else if (vald_din) begin
        d    = int'(data_in);
        cur  = m_idx;
        emit = 0;
        if (m_idx < IDX_MAX) m_idx++;
        if (!m_have_prev) begin
          m_have_prev = 1;
        end else if (m_tracking) begin
          if (d > m_cval) begin
            m_cval = d; m_cidx = cur;
          end else if (d < m_cval) begin
            emit = 1;
          end
        end else if (d > m_prev && d >= int'(threshold) && m_hold == 0) begin
          m_tracking = 1; m_cval = d; m_cidx = cur;
        end
        if (emit) begin
          m_tracking = 0;
          m_pvalid   = 1'b1;
          m_pv       = m_cval;
          m_pi       = m_cidx;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_hold = md;
        end else if (m_hold > 0) begin
          m_hold--;
        end
        m_prev = d;
      end
    end
  endtask

  // One clock: update model, let the edge pass, compare all outputs.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("data_out",   32'(data_out),   32'(m_dout));
    check("valid_out",  32'(valid_out),  32'(m_vout));
    check("peak_valid", 32'(peak_valid), 32'(m_pvalid));
    check("peak_val",   32'(peak_val),   32'(m_pv));
    check("peak_idx",   32'(peak_idx),   32'(m_pi));
    check("peak_cnt",   32'(peak_cnt),   32'(m_cnt));
    if (peak_valid) pk_q.push_back(int'(peak_idx));
  endtask

  task automatic new_action();
    start_act = 1'b1; vald_din = 1'b0;
    cyc();
    start_act = 1'b0;
    pk_q.delete();
  endtask

  task automatic feed_seq();
    foreach (seq[i]) begin
      vald_din = 1'b1;
      data_in  = DW'(seq[i]);
      cyc();
    end
    vald_din = 1'b0;
    cyc();
  endtask

  initial begin
    reset_n = 1'b1; start_act = 1'b0; peakd_en = 1'b0; vald_din = 1'b0;
    data_in = '0; threshold = '0; min_dist = 8'd0;
    cyc();
    cyc();
    check("rst_cnt", 32'(peak_cnt), 32'd0);
    reset_n  = 1'b0;
    peakd_en = 1'b1;

    // basic peak
    threshold = DW'(100);
    new_action();
    seq = '{10, 50, 120, 200, 150};
    feed_seq();
    check("p1_npk", 32'(pk_q.size()), 32'd1);
    check("p1_val", 32'(peak_val), 32'd200);
    check("p1_idx", 32'(peak_idx), 32'd3);
    check("p1_cnt", 32'(peak_cnt), 32'd1);

    // plateau keeps the first index
    new_action();
    seq = '{10, 120, 200, 200, 150};
    feed_seq();
    check("plat_val", 32'(peak_val), 32'd200);
    check("plat_idx", 32'(peak_idx), 32'd2);

    // below threshold
    new_action();
    seq = '{10, 50, 90, 40};
    feed_seq();
    check("thr_npk", 32'(pk_q.size()), 32'd0);
    check("thr_cnt", 32'(peak_cnt), 32'd0);

    // start_act drops a pending candidate and restarts the index
    new_action();
    seq = '{10, 150, 200};
    feed_seq();
    new_action();
    check("sa_cnt", 32'(peak_cnt), 32'd0);
    threshold = DW'(0);
    seq = '{1, 5, 2};
    feed_seq();
    check("sa_npk", 32'(pk_q.size()), 32'd1);
    check("sa_idx", 32'(peak_idx), 32'd1);

    // holdoff pattern
    min_dist = 8'd3;
    new_action();
    seq = '{0, 9, 0, 9, 0, 9, 0, 9, 0};
    feed_seq();
`ifdef PEAKD_HOLDOFF_EN
    exp_q = '{1, 7};
`else
    exp_q = '{1, 3, 5, 7};
`endif
    check("ho_npk", 32'(pk_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < pk_q.size()) check("ho_idx", 32'(pk_q[i]), 32'(exp_q[i]));
    end
    min_dist = 8'd0;

    // valid gap between the peak and the falling sample
    new_action();
    vald_din = 1'b1; data_in = DW'(0); cyc();
    data_in = DW'(9); cyc();
    vald_din = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = DW'(77);
      cyc();
    end
    vald_din = 1'b1; data_in = DW'(0); cyc();
    vald_din = 1'b0; cyc();
    check("gap_npk", 32'(pk_q.size()), 32'd1);
    check("gap_idx", 32'(peak_idx), 32'd1);

    // reset mid-TRACK: candidate is lost
    new_action();
    vald_din = 1'b1; data_in = DW'(10); cyc();
    data_in = DW'(200); cyc();
    reset_n = 1'b1; cyc();
    reset_n = 1'b0;
    data_in = DW'(5); cyc();
    data_in = DW'(3); cyc();
    vald_din = 1'b0; cyc();
    check("rst_npk", 32'(pk_q.size()), 32'd0);
    check("rst_cnt2", 32'(peak_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 199) == 0);
      start_act = ($urandom_range(0, 79) == 0);
      peakd_en  = ($urandom_range(0, 29) != 0);
      vald_din  = ($urandom_range(0, 3) != 0);
      data_in   = ($urandom_range(0, 19) == 0) ? DW'($urandom) : DW'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) threshold = DW'($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) min_dist = 8'($urandom_range(0, 4));
      cyc();
    end
    reset_n = 1'b0; start_act = 1'b0; peakd_en = 1'b1;

    // index and count saturation
    min_dist = 8'd0; threshold = DW'(0);
    new_action();
    for (int i = 0; i < 2200; i++) begin
      vald_din = 1'b1;
      data_in  = (i % 2 == 1) ? DW'(9) : DW'(0);
      cyc();
    end
    vald_din = 1'b0; cyc();
    check("sat_cnt", 32'(peak_cnt), 32'd255);
    check("sat_idx", 32'(peak_idx), 32'd2047);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_detect.md
PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 SHALL have parameter: DATAWIDTH, `DATAWIDTH, sample width matching the moving-average output.
REQ-002 SHALL have parameter: IDXW, 11, sample-index width.
REQ-003 SHALL have parameter: CNTW, 8, peak-count width.
REQ-004 SHALL have port: clk  in  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port: reset_n  in  1  reset; synchronous and active-high (1 = reset, sampled on posedge clk).
REQ-006 SHALL have port: start_act  in  1  start of a new action; clears the detection context.
REQ-007 SHALL have port: peakd_en  in  1  block enable.
REQ-008 SHALL have port: vald_din  in  1  valid sample, driven from the moving-average valid_out.
REQ-009 SHALL have port: data_in  in  DATAWIDTH  filtered sample, driven from the moving-average data_out.
REQ-010 SHALL have port: threshold  in  DATAWIDTH  minimum peak amplitude (unsigned).
REQ-011 SHALL have port: data_out  out  DATAWIDTH  data_in delayed by 1 cycle.
REQ-012 SHALL have port: valid_out  out  1  vald_din delayed by 1 cycle.
REQ-013 SHALL have port: peak_valid  out  1  one-cycle pulse per detected peak.
REQ-014 SHALL have port: peak_val  out  DATAWIDTH  amplitude of the last peak.
REQ-015 SHALL have port: peak_idx  out  IDXW  sample index of the last peak.
REQ-016 SHALL have port: peak_cnt  out  CNTW  number of peaks since start_act.

Function
REQ-017 The block SHALL treat a sample as accepted only when vald_din=1; gaps SHALL stall all state.
REQ-018 The sample index SHALL be 0 for the first accepted sample after start_act or peakd_en rising, increment by 1 per accepted sample, and saturate at 2^IDXW-1.
REQ-019 The FSM SHALL have states IDLE, SEEK and TRACK, and SHALL hold last, the previous accepted sample.
REQ-020 In IDLE, an accepted sample SHALL set last=data_in and move to SEEK.
REQ-021 In SEEK, an accepted sample d SHALL move to TRACK with cand_val=d and cand_idx=index when d>last and d>=threshold (holdoff permitting); last SHALL be set to d in all cases.
REQ-022 In TRACK, an accepted d>cand_val SHALL update cand_val and cand_idx; d==cand_val SHALL hold the candidate, so a plateau keeps its first index.
REQ-023 In TRACK, an accepted d<cand_val SHALL emit the candidate and return to SEEK.
REQ-024 On emission, peak_valid SHALL pulse high on the cycle after the falling sample is accepted, with peak_val and peak_idx updated in that same cycle.
REQ-025 peak_val and peak_idx SHALL hold until the next emission.
REQ-026 On emission, peak_cnt SHALL increment, saturating at 2^CNTW-1.
REQ-027 start_act=1 SHALL force IDLE, zero the index, peak_cnt, peak_val and peak_idx, and clear any pending candidate without emitting it; start_act SHALL take priority over a simultaneous sample.
REQ-028 peakd_en=0 SHALL hold the FSM in IDLE and keep peak_valid=0; data_out and valid_out SHALL still pass through.
REQ-029 All comparisons SHALL be unsigned at DATAWIDTH bits.

Reset
REQ-030 reset_n=1 at a clock edge SHALL zero every register and output and force IDLE, including mid-TRACK; no peak SHALL be emitted for the interrupted candidate.
REQ-031 Reset SHALL take priority over start_act.

Configuration
REQ-032 The macro PEAKD_HOLDOFF_EN, when defined, SHALL add input min_dist[7:0].
REQ-033 With PEAKD_HOLDOFF_EN, each emission SHALL load a holdoff counter with min_dist; the counter SHALL decrement per accepted sample down to 0.
REQ-034 With PEAKD_HOLDOFF_EN, SEEK SHALL NOT enter TRACK while the holdoff counter is nonzero.
REQ-035 With PEAKD_HOLDOFF_EN, start_act and reset SHALL clear the holdoff counter.
REQ-036 Without PEAKD_HOLDOFF_EN, the min_dist port and the holdoff logic SHALL be absent, and SEEK SHALL enter TRACK with no holdoff.

Structure
REQ-037 Package peakd_pkg SHALL hold the FSM state enum (IDLE/SEEK/TRACK) and the IDXW and CNTW default constants.
REQ-038 A single sub-module, peakd_holdoff, SHALL implement the holdoff counter and SHALL be instantiated only under PEAKD_HOLDOFF_EN.

Verification
REQ-039 threshold=100, samples 10,50,120,200,150 -> one peak_valid pulse, the cycle after 150 is accepted, with peak_val=200, peak_idx=3, peak_cnt=1.
REQ-040 threshold=100, samples 10,120,200,200,150 -> peak_val=200, peak_idx=2.
REQ-041 threshold=100, samples 10,50,90,40 -> no peak_valid pulse; peak_cnt=0.
REQ-042 threshold=100, samples 10,150,200 then start_act=1 -> no pulse; peak_cnt=0; the next accepted sample has index 0.
REQ-043 With PEAKD_HOLDOFF_EN, min_dist=3, threshold=0, samples 0,9,0,9,0,9,0,9,0 -> peaks at idx 1 and 7 only; without the macro -> peaks at idx 1, 3, 5 and 7.
REQ-044 Samples 0,9,0 with vald_din low for 4 cycles between the 9 and the 0 -> a single pulse with peak_idx=1.
